vending_machine_change: RTL and testbench

Parametrised successor to the fixed-price nickel/dime Mealy vending machine. It accepts nickels, dimes and quarters against a configurable price. It vends with a Mealy `open` pulse and returns change or refunds one coin per cycle. It sits between the coin-acceptor pulse interface and the product-release and coin-return actuators.

---
 rtl/vending_machine_change.sv | 122 ++++++++++++
 tb/tb_vending_machine_change.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vending_machine_change.sv
// Coin-collecting vending controller with configurable price.
// Vends on a Mealy open pulse, then pays change one coin per cycle.
module vending_machine_change #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                N,
  input  logic                D,
  input  logic                Q,
  input  logic                cancel,
  output logic                open,
  output logic                change_n,
  output logic                change_d,
  output logic                reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic {
    COLLECT,
    CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] FIVE    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] TEN     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] QUARTER = CREDIT_W'(25);

  state_t              state;
  state_t              state_nx;
  logic [CREDIT_W-1:0] remain;
  logic [CREDIT_W-1:0] remain_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                reject_nx;
  logic                any;
  logic                multi;
  logic                single;

  always_comb begin
    any    = N | D | Q;
    multi  = (N & D) | (N & Q) | (D & Q);
    single = any & ~multi;
    unique case (1'b1)
      single & N: coin_val = FIVE;
      single & D: coin_val = TEN;
      single & Q: coin_val = QUARTER;
      default:    coin_val = '0;
    endcase
    sum = credit + coin_val;
  end

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    remain_nx = remain;
    reject_nx = 1'b0;
    open      = 1'b0;
    change_n  = 1'b0;
    change_d  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      COLLECT: begin
        if (cancel) begin
          reject_nx = any;
          if (credit != '0) begin
            state_nx  = CHANGE;
            remain_nx = credit;
            credit_nx = '0;
          end
        end else if (multi) begin
          reject_nx = 1'b1;
        end else if (single) begin
          if (sum < PRICE_V) begin
            credit_nx = sum;
          end else begin
            open      = 1'b1;
            credit_nx = '0;
            if (sum != PRICE_V) begin
              state_nx  = CHANGE;
              remain_nx = sum - PRICE_V;
            end
          end
        end
      end
      CHANGE: begin
        busy      = 1'b1;
        reject_nx = any;
        // Dimes first; a lone trailing nickel finishes an odd amount.
        if (remain >= TEN) begin
          change_d  = 1'b1;
          remain_nx = remain - TEN;
        end else if (remain == FIVE) begin
          change_n  = 1'b1;
          remain_nx = '0;
        end else begin
          remain_nx = '0;
        end
        if (remain_nx == '0) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= COLLECT;
      credit <= '0;
      remain <= '0;
      reject <= 1'b0;
    end else begin
      state  <= state_nx;
      credit <= credit_nx;
      remain <= remain_nx;
      reject <= reject_nx;
    end
  end

endmodule

// File: tb/tb_vending_machine_change.sv
// Scoreboard bench: per-cycle expectations queued by stimulus,
// popped and compared by a negedge monitor.
module tb_vending_machine_change;

  typedef struct packed {
    logic       sel;
    logic       op;
    logic       cn;
    logic       cd;
    logic       rj;
    logic       by;
    logic [7:0] cr;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic n1 = 1'b0, d1 = 1'b0, q1 = 1'b0, c1 = 1'b0;
  logic n2 = 1'b0, d2 = 1'b0, q2 = 1'b0, c2 = 1'b0;
  logic op1, cn1, cd1, rj1, by1;
  logic op2, cn2, cd2, rj2, by2;
  logic [7:0] cr1, cr2;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  string name_q[$];

  vending_machine_change #(.PRICE(15), .CREDIT_W(8)) dut1 (
    .clk(clk), .rstn(rstn), .N(n1), .D(d1), .Q(q1),
    .cancel(c1), .open(op1), .change_n(cn1),
    .change_d(cd1), .reject(rj1), .busy(by1), .credit(cr1)
  );

  vending_machine_change #(.PRICE(30), .CREDIT_W(8)) dut2 (
    .clk(clk), .rstn(rstn), .N(n2), .D(d2), .Q(q2),
    .cancel(c2), .open(op2), .change_n(cn2),
    .change_d(cd2), .reject(rj2), .busy(by2), .credit(cr2)
  );

  always #5 clk = ~clk;

  task automatic cyc(
    input string nm, input logic sel, input logic rst,
    input logic n, input logic d, input logic q, input logic c,
    input logic op, input logic cn, input logic cd,
    input logic rj, input logic by, input logic [7:0] cr
  );
    exp_t e;
    @(posedge clk);
    #1;
    rstn = ~rst;
    {n1, d1, q1, c1} = sel ? 4'b0 : {n, d, q, c};
    {n2, d2, q2, c2} = sel ? {n, d, q, c} : 4'b0;
    e = '{sel: sel, op: op, cn: cn, cd: cd, rj: rj, by: by, cr: cr};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    string nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.sel) a = '{1'b1, op2, cn2, cd2, rj2, by2, cr2};
      else       a = '{1'b0, op1, cn1, cd1, rj1, by1, cr1};
      checks++;
      if (a != e) begin
        errors++;
        $display("FAIL %s: got open=%0b cn=%0b cd=%0b rej=%0b busy=%0b credit=%0d, expected open=%0b cn=%0b cd=%0b rej=%0b busy=%0b credit=%0d",
                 nm, a.op, a.cn, a.cd, a.rj, a.by, a.cr,
                 e.op, e.cn, e.cd, e.rj, e.by, e.cr);
      end
    end
    checks++;
    if ((cn1 & cd1) | (cn2 & cd2)) begin
      errors++;
      $display("FAIL both_change: got cn=%0b cd=%0b, expected not both", cn1, cd1);
    end
    checks++;
    if ((op1 & by1) | (op2 & by2)) begin
      errors++;
      $display("FAIL open_busy: got open=%0b busy=%0b, expected not both", op1, by1);
    end
  end

  initial begin
    // name sel rst N D Q cancel | open cn cd rej busy credit
    cyc("reset",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("nd_n",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("nd_d",       0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'd5);
    cyc("nd_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("n3_1",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("n3_2",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd5);
    cyc("n3_3",       0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd10);
    cyc("n3_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("q_vend",     0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'd0);
    cyc("q_chg",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'd0);
    cyc("q_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("dq_d",       0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("dq_q",       0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'd10);
    cyc("dq_chg1",    0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 8'd0);
    cyc("dq_chg2",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'd0);
    cyc("dq_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("dc_d",       0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("dc_cancel",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'd10);
    cyc("dc_chg",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'd0);
    cyc("dc_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("nc_n",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("nc_cancel",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'd5);
    cyc("nc_chg",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'd0);
    cyc("nc_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("c0_cancel",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'd0);
    cyc("c0_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("m_n",        0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("m_nd",       0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 8'd5);
    cyc("m_rej",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'd5);
    cyc("m_after",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd5);
    cyc("m_cancel",   0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 8'd5);
    cyc("m_chg",      0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 8'd0);
    cyc("m_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("rm_q",       0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'd0);
    cyc("rm_rst",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("rm_rel",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("nq_n",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("nq_q",       0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8'd5);
    cyc("nq_dime",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 8'd0);
    cyc("nq_nickel",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'd0);
    cyc("nq_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("p30_q",      1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'd0);
    cyc("p30_n",      1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8'd25);
    cyc("p30_idle",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
